// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with a req/ack wait-state handshake and misalignment rejection.
// Optional range check: define DMEM_BOUNDS_CHECK_EN to reject addresses >= DEPTH_WORDS*4.
module dmem_bytelane #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LOW_W = IDX_W + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, sext_q;
  logic [1:0]        size_q;
  logic [LOW_W-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              commit, reject_fire;

  logic [31:0]       mem_q [DEPTH_WORDS];

  // In IDLE the access is taken straight from the ports so a zero-wait commit needs no extra cycle.
  logic              in_idle;
  logic              c_we, c_sext;
  logic [1:0]        c_size;
  logic [LOW_W-1:0]  c_addr;
  logic [31:0]       c_wdata;

  assign in_idle = (state_q == S_IDLE);
  assign c_we    = in_idle ? we    : we_q;
  assign c_sext  = in_idle ? sext  : sext_q;
  assign c_size  = in_idle ? size  : size_q;
  assign c_addr  = in_idle ? addr[LOW_W-1:0] : addr_q;
  assign c_wdata = in_idle ? wdata : wdata_q;

  logic is_byte, is_half, misaligned, reject;
  assign is_byte    = (c_size == 2'b00);
  assign is_half    = (c_size == 2'b01);
  assign misaligned = (is_half && c_addr[0]) || (!is_byte && !is_half && (c_addr[1:0] != 2'b00));

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);
  assign reject = misaligned || (addr >= MEM_BYTES);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_WIDTH-1:LOW_W];
  assign reject = misaligned;
`endif

  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [3:0]        byte_en;
  logic [3:0][7:0]   wr_lanes;

  assign idx     = c_addr[LOW_W-1:2];
  assign rd_word = mem_q[idx];
  assign ld_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
  assign ld_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign ld_val  = is_byte ? {{24{c_sext & ld_byte[7]}}, ld_byte} :
                   is_half ? {{16{c_sext & ld_half[15]}}, ld_half} : rd_word;

  // Right-aligned store data is replicated onto the lanes; byte_en picks the ones that land.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_en[gi]  = is_byte ? (c_addr[1:0] == 2'(gi)) :
                          is_half ? (c_addr[1] == 1'(gi / 2)) : 1'b1;
    assign wr_lanes[gi] = is_byte ? c_wdata[7:0] :
                          is_half ? c_wdata[8*(gi%2) +: 8] : c_wdata[8*gi +: 8];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    reject_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (reject) begin
            reject_fire = 1'b1;
            state_d     = S_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            commit  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        addr_q  <= addr[LOW_W-1:0];
        wdata_q <= wdata;
      end
      if (commit) begin
        err_q   <= 1'b0;
        rdata_q <= c_we ? 32'd0 : ld_val;
      end else if (reject_fire) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end
    end
  end

  // Storage is never reset; it only changes on a store commit.
  always_ff @(posedge clk) begin
    if (commit && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[idx][8*i +: 8] <= wr_lanes[i];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: directed table, busy/reset sequences, and random traffic vs a byte-array model.
module tb_dmem_bytelane;
  localparam int WAITC     = 1;
  localparam int DEPTH     = 128;
  localparam int AW        = 32;
  localparam int MEM_BYTES = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   rdata;
  logic          ack, err, busy;

  always #5 clk = ~clk;

  dmem_bytelane #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory is a flat little-endian byte array.
  logic [7:0] bytes_m [MEM_BYTES];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic m_we, input logic [1:0] m_size, input logic m_sext,
                                input logic [31:0] m_addr, input logic [31:0] m_wdata,
                                output logic [31:0] m_rd, output logic m_err, output int m_lat);
    int n;
    bit oob;
    int base;
    logic [31:0] v;
    n = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
    oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = (m_addr >= 32'(MEM_BYTES));
`endif
    if ((m_addr % 32'(n)) != 0 || oob) begin
      m_rd = 32'd0; m_err = 1'b1; m_lat = 1;
      return;
    end
    m_err = 1'b0;
    m_lat = 1 + WAITC;
    base = int'(m_addr % 32'(MEM_BYTES));
    if (m_we) begin
      for (int i = 0; i < n; i++) bytes_m[base + i] = m_wdata[8*i +: 8];
      m_rd = 32'd0;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = bytes_m[base + i];
      if (n < 4 && m_sext && v[8*n - 1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      m_rd = v;
    end
  endfunction

  // Starts and ends #1 after a rising edge; lat counts edges from request to first visible ack.
  task automatic run_access(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                            input logic [31:0] t_addr, input logic [31:0] t_wdata,
                            output logic [31:0] o_rd, output logic o_err, output int o_lat);
    req = 1'b1; we = t_we; size = t_size; sext = t_sext; addr = t_addr; wdata = t_wdata;
    @(posedge clk); #1;
    req = 1'b0;
    o_lat = 1;
    while (!ack && o_lat < 40) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_rd = rdata;
    o_err = err;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack}, 32'd0);
    $display("txn we=%0d size=%0d sext=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             t_we, t_size, t_sext, t_addr, t_wdata, o_rd, o_err, o_lat);
  endtask

  task automatic add_vec(input logic v_we, input logic [1:0] v_size, input logic v_sext,
                         input logic [31:0] v_addr, input logic [31:0] v_wdata,
                         input logic [31:0] v_rd, input logic v_err, input int v_lat);
    vec_t v;
    v.we = v_we; v.size = v_size; v.sext = v_sext; v.addr = v_addr; v.wdata = v_wdata;
    v.exp_rd = v_rd; v.exp_err = v_err; v.exp_lat = v_lat;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, m_rd;
    logic        e, m_e;
    int          lat, m_lat, acks;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_we, r_sext;

    for (int i = 0; i < MEM_BYTES; i++) bytes_m[i] = 8'h00;

    // Directed vectors; aligned accesses ack 1+WAITC edges after the request, rejects after 1.
    add_vec(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
    add_vec(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
    add_vec(1, 2'd0, 0, 32'h11, 32'h123456AA, 32'h0,        0, 2);
    add_vec(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADAAEF, 0, 2);
    add_vec(0, 2'd0, 1, 32'h11, 32'h0,        32'hFFFFFFAA, 0, 2);
    add_vec(0, 2'd0, 0, 32'h11, 32'h0,        32'h000000AA, 0, 2);
    add_vec(0, 2'd1, 1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2);
    add_vec(0, 2'd1, 0, 32'h12, 32'h0,        32'h0000DEAD, 0, 2);
    add_vec(0, 2'd2, 0, 32'h13, 32'h0,        32'h0,        1, 1);
    add_vec(1, 2'd1, 0, 32'h11, 32'h00001111, 32'h0,        1, 1);
    add_vec(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADAAEF, 0, 2);
    add_vec(1, 2'd1, 0, 32'h12, 32'h9999BEEF, 32'h0,        0, 2);
    add_vec(0, 2'd2, 0, 32'h10, 32'h0,        32'hBEEFAAEF, 0, 2);
    add_vec(0, 2'd0, 1, 32'h13, 32'h0,        32'hFFFFFFBE, 0, 2);
    add_vec(0, 2'd3, 0, 32'h10, 32'h0,        32'hBEEFAAEF, 0, 2);
    add_vec(0, 2'd1, 1, 32'h10, 32'h0,        32'hFFFFAAEF, 0, 2);
`ifdef DMEM_BOUNDS_CHECK_EN
    add_vec(1, 2'd2, 0, 32'h200,      32'h12345678, 32'h0, 1, 1);
    add_vec(0, 2'd2, 0, 32'h0,        32'h0,        32'h0, 0, 2);
    add_vec(0, 2'd2, 0, 32'hFFFFFE10, 32'h0,        32'h0, 1, 1);
`else
    add_vec(1, 2'd2, 0, 32'h200,      32'h12345678, 32'h0,        0, 2);
    add_vec(0, 2'd2, 0, 32'h0,        32'h0,        32'h12345678, 0, 2);
    add_vec(0, 2'd2, 0, 32'hFFFFFE10, 32'h0,        32'hBEEFAAEF, 0, 2);
`endif

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known memory contents regardless of power-up state
    for (int w = 0; w < DEPTH; w++) begin
      run_access(1, 2'd2, 0, 32'(w * 4), 32'd0, rd, e, lat);
      model(1, 2'd2, 0, 32'(w * 4), 32'd0, m_rd, m_e, m_lat);
    end

    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      model(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, m_rd, m_e, m_lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Second request while busy must be dropped
    req = 1'b1; we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h40; wdata = 32'h11111111;
    @(posedge clk); #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wdata = 32'h22222222;
    acks = 0;
    @(posedge clk); #1; acks += int'(ack);
    @(posedge clk); #1; acks += int'(ack);
    req = 1'b0;
    repeat (6) begin
      @(posedge clk); #1; acks += int'(ack);
    end
    chk("busy_ignore_ack_count", 32'(acks), 32'd1);
    $display("txn busy-overlap store 0x11111111/0x22222222 @0x40 -> acks=%0d", acks);
    model(1, 2'd2, 0, 32'h40, 32'h11111111, m_rd, m_e, m_lat);
    run_access(0, 2'd2, 0, 32'h40, 32'h0, rd, e, lat);
    model(0, 2'd2, 0, 32'h40, 32'h0, m_rd, m_e, m_lat);
    chk("busy_ignore_mem", rd, m_rd);

    // Reset during WAIT drops the pending store
    run_access(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, rd, e, lat);
    model(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, m_rd, m_e, m_lat);
    run_access(0, 2'd2, 0, 32'h20, 32'h0, rd, e, lat);
    model(0, 2'd2, 0, 32'h20, 32'h0, m_rd, m_e, m_lat);
    chk("pre_reset_load", rd, m_rd);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h5;
    @(posedge clk); #1;
    req = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_rdata", rdata, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_ack", {31'd0, ack}, 32'd0);
    chk("midreset_err", {31'd0, err}, 32'd0);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1; acks += int'(ack);
    end
    chk("midreset_no_ack", 32'(acks), 32'd0);
    $display("txn reset during WAIT of store 0x5 @0x20 -> acks=%0d", acks);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_access(0, 2'd2, 0, 32'h20, 32'h0, rd, e, lat);
    model(0, 2'd2, 0, 32'h20, 32'h0, m_rd, m_e, m_lat);
    chk("post_reset_load", rd, m_rd);

    // Random traffic against the byte-array model
    for (int t = 0; t < 300; t++) begin
      r_we   = 1'($urandom % 2);
      r_size = 2'($urandom % 4);
      r_sext = 1'($urandom % 2);
      if ($urandom % 8 == 0) r_addr = $urandom;
      else r_addr = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom % 3 != 0) r_addr = r_addr & ~32'd3;
      run_access(r_we, r_size, r_sext, r_addr, $urandom, rd, e, lat);
      model(r_we, r_size, r_sext, r_addr, wdata, m_rd, m_e, m_lat);
      chk($sformatf("rand%0d_rdata", t), rd, m_rd);
      chk($sformatf("rand%0d_err", t), {31'd0, e}, {31'd0, m_e});
      chk($sformatf("rand%0d_latency", t), 32'(lat), 32'(m_lat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
